// File: rtl/run_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : run_controller_if
// Purpose  : Control, core-side and status signals of the run/step/halt
//            sequencer, bundled with driver (master) and controller (slave) views.
// Revision : 1.0
// ============================================================================
interface run_controller_if #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
);
    logic             start;
    logic             step;
    logic             resume;
    logic             halt_req;
    logic             bp_en;
    logic [PC_W-1:0]  bp_addr;
    logic [CNT_W-1:0] cycle_limit;
    logic [PC_W-1:0]  pc;
    logic             cpu_en;
    logic             cpu_rst_n;
    logic             running;
    logic             halted;
    logic [2:0]       state;
    logic [CNT_W-1:0] cycle_count;
    logic [1:0]       halt_cause;

    modport master (
        output start, step, resume, halt_req, bp_en, bp_addr, cycle_limit, pc,
        input  cpu_en, cpu_rst_n, running, halted, state, cycle_count, halt_cause
    );

    modport slave (
        input  start, step, resume, halt_req, bp_en, bp_addr, cycle_limit, pc,
        output cpu_en, cpu_rst_n, running, halted, state, cycle_count, halt_cause
    );
endinterface
`default_nettype wire

// File: rtl/run_controller.sv
`default_nettype none
// ============================================================================
// Module   : run_controller
// Purpose  : Run/step/halt sequencer gating the core's state updates through
//            a clock enable, with cycle counting, breakpoint and cycle limit.
// Revision : 1.0
// ============================================================================
module run_controller #(
    parameter int PC_W       = 32,
    parameter int CNT_W      = 16,
    parameter int RST_CYCLES = 2
) (
    input wire              clk,
    input wire              rst_n,
    run_controller_if.slave ctl
);

    localparam int               RC_W       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RC_W-1:0]  C_RST_LAST = RC_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CPURST = 3'd1,
        S_RUN    = 3'd2,
        S_STEP   = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cycle_count;
    logic [1:0]       r_halt_cause;
    logic             r_skip_bp;
    logic [RC_W-1:0]  r_rst_cnt;

    logic [PC_W-1:0]  w_pc_diff;
    logic             w_bp_hit;
    logic             w_lim_hit;
    logic             w_stop;
    logic [1:0]       w_cause;
    logic             w_cpu_en;
    logic             w_clear;
    logic             w_set_skip;

    assign w_pc_diff = ctl.pc ^ ctl.bp_addr;
    assign w_bp_hit  = ctl.bp_en && (w_pc_diff == '0) && !r_skip_bp;
    assign w_lim_hit = (ctl.cycle_limit != '0) && (r_cycle_count == ctl.cycle_limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_stop      = 1'b0;
        w_cause     = 2'd0;
        w_cpu_en    = 1'b0;
        w_clear     = 1'b0;
        w_set_skip  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ctl.start) begin
                    w_state_nxt = S_CPURST;
                    w_clear     = 1'b1;
                end
            end
            S_CPURST: begin
                if (r_rst_cnt == C_RST_LAST) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // Priority order decides the reported cause when several fire together.
                if (ctl.halt_req) begin
                    w_cause = 2'd1;
                end else if (w_bp_hit) begin
                    w_cause = 2'd2;
                end else if (w_lim_hit) begin
                    w_cause = 2'd3;
                end
                w_stop = ctl.halt_req || w_bp_hit || w_lim_hit;
                if (w_stop) begin
                    w_state_nxt = S_HALTED;
                end else begin
                    w_cpu_en = 1'b1;
                end
            end
            S_STEP: begin
                w_cpu_en    = 1'b1;
                w_state_nxt = S_HALTED;
            end
            S_HALTED: begin
                if (ctl.start) begin
                    w_state_nxt = S_CPURST;
                    w_clear     = 1'b1;
                end else if (ctl.resume) begin
                    w_state_nxt = S_RUN;
                    w_set_skip  = 1'b1;
                end else if (ctl.step) begin
                    w_state_nxt = S_STEP;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle_count <= '0;
            r_halt_cause  <= 2'd0;
            r_skip_bp     <= 1'b0;
            r_rst_cnt     <= '0;
        end else begin
            if (w_clear) begin
                r_cycle_count <= '0;
                r_halt_cause  <= 2'd0;
                r_rst_cnt     <= '0;
            end else begin
                if (w_cpu_en && (r_cycle_count != C_CNT_MAX)) begin
                    r_cycle_count <= r_cycle_count + 1'b1;
                end
                if ((r_state == S_CPURST) && (r_rst_cnt != C_RST_LAST)) begin
                    r_rst_cnt <= r_rst_cnt + 1'b1;
                end
                if ((r_state == S_RUN) && w_stop) begin
                    r_halt_cause <= w_cause;
                end
            end
            // The breakpoint mask lives for exactly one RUN cycle after resume.
            if (w_set_skip) begin
                r_skip_bp <= 1'b1;
            end else if (r_state == S_RUN) begin
                r_skip_bp <= 1'b0;
            end
        end
    end

    assign ctl.cpu_en      = w_cpu_en;
    assign ctl.cpu_rst_n   = !((r_state == S_IDLE) || (r_state == S_CPURST));
    assign ctl.running     = (r_state == S_RUN) || (r_state == S_STEP);
    assign ctl.halted      = (r_state == S_HALTED);
    assign ctl.state       = r_state;
    assign ctl.cycle_count = r_cycle_count;
    assign ctl.halt_cause  = r_halt_cause;

endmodule
`default_nettype wire

// File: tb/tb_run_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_run_controller
// Purpose  : Directed self-checking bench for run_controller with a small
//            core PC model and an expected-state scoreboard.
// Revision : 1.0
// ============================================================================
module tb_run_controller;

    localparam int PC_W  = 32;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    run_controller_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus   ();
    run_controller_if #(.PC_W(PC_W), .CNT_W(4))     bus_s ();

    run_controller #(.PC_W(PC_W), .CNT_W(CNT_W), .RST_CYCLES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctl   (bus.slave)
    );

    run_controller #(.PC_W(PC_W), .CNT_W(4), .RST_CYCLES(2)) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .ctl   (bus_s.slave)
    );

    // Core model: PC resets while held, advances by 4 on each enabled edge.
    logic [PC_W-1:0] core_pc;
    always @(posedge clk) begin
        if (bus.cpu_rst_n !== 1'b1) core_pc <= '0;
        else if (bus.cpu_en === 1'b1) core_pc <= core_pc + 32'd4;
    end
    assign bus.pc   = core_pc;
    assign bus_s.pc = '0;

    int en_pulses = 0;
    always @(negedge clk) begin
        if (bus.cpu_en === 1'b1) en_pulses <= en_pulses + 1;
    end

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [2:0] state;
        logic       cpu_en;
        logic       cpu_rst_n;
        int         count;
        logic [1:0] cause;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [2:0] st, input logic en,
                        input logic rn, input int cnt, input logic [1:0] cause);
        exp_t e;
        e.tag = tag; e.state = st; e.cpu_en = en; e.cpu_rst_n = rn;
        e.count = cnt; e.cause = cause;
        sb.push_back(e);
    endtask

    task automatic sb_check();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".state"},     {29'd0, bus.state},      {29'd0, e.state});
            chk({e.tag, ".cpu_en"},    {31'd0, bus.cpu_en},     {31'd0, e.cpu_en});
            chk({e.tag, ".cpu_rst_n"}, {31'd0, bus.cpu_rst_n},  {31'd0, e.cpu_rst_n});
            chk({e.tag, ".running"},   {31'd0, bus.running},
                {31'd0, (e.state == 3'd2) || (e.state == 3'd3)});
            chk({e.tag, ".halted"},    {31'd0, bus.halted},     {31'd0, e.state == 3'd4});
            chk({e.tag, ".count"},     {16'd0, bus.cycle_count}, e.count);
            chk({e.tag, ".cause"},     {30'd0, bus.halt_cause}, {30'd0, e.cause});
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic check();
        #1;
        sb_check();
    endtask

    int base;
    logic [PC_W-1:0] pc_hold;

    initial begin
        rst_n = 1'b0;
        bus.start = 0; bus.step = 0; bus.resume = 0; bus.halt_req = 0;
        bus.bp_en = 0; bus.bp_addr = '0; bus.cycle_limit = '0;
        bus_s.start = 0; bus_s.step = 0; bus_s.resume = 0; bus_s.halt_req = 0;
        bus_s.bp_en = 0; bus_s.bp_addr = '0; bus_s.cycle_limit = '0;

        #3;
        push("reset", 3'd0, 0, 0, 0, 0); sb_check();
        next(); next();
        rst_n = 1'b1;
        next();
        push("idle", 3'd0, 0, 0, 0, 0); check();

        // Start, reset hold, free run
        bus.start = 1; next(); bus.start = 0;
        push("cpurst1", 3'd1, 0, 0, 0, 0); check();
        next();
        push("cpurst2", 3'd1, 0, 0, 0, 0); check();
        next();
        push("run0", 3'd2, 1, 1, 0, 0); check();
        repeat (5) next();
        push("run5", 3'd2, 1, 1, 5, 0); check();
        chk("run5_pc", core_pc, 32'h14);
        bus.halt_req = 1;
        push("hreq_gate", 3'd2, 0, 1, 5, 0); check();
        next(); bus.halt_req = 0;
        push("halted_ext", 3'd4, 0, 1, 5, 1); check();

        // Cycle limit
        bus.cycle_limit = 16'd10;
        bus.start = 1; next(); bus.start = 0;
        push("restart_lim", 3'd1, 0, 0, 0, 0); check();
        base = en_pulses;
        for (int i = 0; i < 40 && bus.halted !== 1'b1; i++) next();
        chk("limit_wait", {31'd0, bus.halted}, 32'd1);
        push("halted_lim", 3'd4, 0, 1, 10, 3); check();
        chk("limit_pulses", en_pulses - base, 32'd10);
        base = en_pulses;
        bus.resume = 1; next(); bus.resume = 0;
        push("resume_at_lim", 3'd2, 0, 1, 10, 3); check();
        next();
        push("rehalt_lim", 3'd4, 0, 1, 10, 3); check();
        chk("resume_pulses", en_pulses - base, 32'd0);
        bus.step = 1; next(); bus.step = 0;
        push("step_lim", 3'd3, 1, 1, 10, 3); check();
        next();
        push("step_lim_done", 3'd4, 0, 1, 11, 3); check();

        // Breakpoint at 0x0C
        bus.cycle_limit = '0; bus.bp_en = 1; bus.bp_addr = 32'h0C;
        bus.start = 1; next(); bus.start = 0;
        push("restart_bp", 3'd1, 0, 0, 0, 0); check();
        for (int i = 0; i < 40 && bus.halted !== 1'b1; i++) next();
        chk("bp_wait", {31'd0, bus.halted}, 32'd1);
        push("halted_bp", 3'd4, 0, 1, 3, 2); check();
        chk("bp_pc", core_pc, 32'h0C);
        bus.resume = 1; next(); bus.resume = 0;
        push("resume_bp", 3'd2, 1, 1, 3, 2); check();
        next();
        push("past_bp", 3'd2, 1, 1, 4, 2); check();
        chk("pc_past_bp", core_pc, 32'h10);

        // halt_req coinciding with a breakpoint match, then single steps
        pc_hold = core_pc + 32'd4;
        bus.bp_addr = pc_hold;
        next();
        bus.halt_req = 1;
        push("hreq_and_bp", 3'd2, 0, 1, 5, 2); check();
        next(); bus.halt_req = 0;
        push("halted_hreq", 3'd4, 0, 1, 5, 1); check();
        base = en_pulses;
        for (int k = 0; k < 3; k++) begin
            bus.step = 1; next(); bus.step = 0;
            push("step_run", 3'd3, 1, 1, 5 + k, 1); check();
            next();
            push("step_halt", 3'd4, 0, 1, 6 + k, 1); check();
        end
        chk("step_pulses", en_pulses - base, 32'd3);
        chk("step_pc", core_pc, pc_hold + 32'd12);

        // start wins over resume and step
        bus.bp_en = 0;
        bus.start = 1; bus.resume = 1; bus.step = 1; next();
        bus.start = 0; bus.resume = 0; bus.step = 0;
        push("start_prio", 3'd1, 0, 0, 0, 0); check();
        next(); next();
        push("run_again", 3'd2, 1, 1, 0, 0); check();
        next(); next();

        // Asynchronous reset mid-cycle
        #2;
        rst_n = 1'b0;
        #1;
        push("async_rst", 3'd0, 0, 0, 0, 0); sb_check();
        next();
        rst_n = 1'b1;

        // Saturation on the 4-bit counter instance
        bus_s.start = 1; next(); bus_s.start = 0;
        repeat (25) next();
        chk("sat_count", {28'd0, bus_s.cycle_count}, 32'd15);
        chk("sat_state", {29'd0, bus_s.state}, 32'd2);
        chk("sat_en", {31'd0, bus_s.cpu_en}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/run_controller.md
# run_controller

Run/step/halt sequencer for the single-cycle processor. It holds the core in reset and then releases it, and it gates every architectural state update through a clock enable. It also counts executed cycles and halts the core on an external request, a PC breakpoint or a cycle limit. It sits between the top-level clock and the `arch` core and replaces free-running clock pulsing as the way to run programs for a bounded number of cycles.

## Interface
- `PC_W`, 32: width of the processor PC and the breakpoint address.
- `CNT_W`, 16: width of the cycle counter and the cycle limit.
- `RST_CYCLES`, 2: number of cycles the core reset is held in CPURST (≥1).

- `clk` in 1: single system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: level sampled per cycle; (re)start program from reset.
- `step` in 1: execute exactly one instruction while halted.
- `resume` in 1: leave HALTED and continue running.
- `halt_req` in 1: external halt request.
- `bp_en` in 1: breakpoint enable.
- `bp_addr` in PC_W: breakpoint address.
- `cycle_limit` in CNT_W: halt when `cycle_count` reaches this value; 0 = unlimited.
- `pc` in PC_W: core PC, i.e. the instruction that executes if `cpu_en`=1 this cycle.
- `cpu_en` out 1: core commits PC/regfile/memory at the next rising edge only when 1.
- `cpu_rst_n` out 1: active-low reset to the core.
- `running` out 1: state is RUN or STEP.
- `halted` out 1: state is HALTED.
- `state` out 3: IDLE=0, CPURST=1, RUN=2, STEP=3, HALTED=4.
- `cycle_count` out CNT_W: number of enabled cycles since the last start.
- `halt_cause` out 2: 0 none, 1 external, 2 breakpoint, 3 limit.

## Operation
- Stop condition `stop`, combinational in RUN, evaluated in this priority order:
  - `halt_req` (cause 1).
  - `bp_en && pc==bp_addr && !skip_bp` (cause 2).
  - `cycle_limit!=0 && cycle_count==cycle_limit` (cause 3).
- Outputs decoded from state:
  - `cpu_rst_n` = 0 in IDLE and CPURST, otherwise 1.
  - `cpu_en` = 1 in STEP, and in RUN when `!stop`; otherwise 0.
- `cycle_count` increments on every cycle with `cpu_en`=1. It saturates at 2^CNT_W−1 and does not wrap.
- State transitions:
  - IDLE: `start` → CPURST; clear `cycle_count`, `halt_cause` and the reset counter.
  - CPURST: stay for exactly RST_CYCLES cycles, then → RUN. `start` here is ignored.
  - RUN, `stop`=1: → HALTED and latch the cause into `halt_cause`; no instruction executes that cycle.
  - RUN, `stop`=0: stay in RUN; `skip_bp` clears after any RUN cycle.
  - RUN: `start`, `step` and `resume` are ignored.
  - HALTED: priority is `start` > `resume` > `step`.
    - `start` → CPURST, with the same clears as from IDLE.
    - `resume` → RUN; set `skip_bp`=1 so the instruction at the breakpoint PC executes once.
    - `step` → STEP.
  - STEP: one cycle with `cpu_en`=1 unconditionally (`halt_req`, breakpoint and limit are ignored), then → HALTED. `halt_cause` is unchanged.
- Resuming while `cycle_count==cycle_limit` re-halts immediately with cause 3. Step remains usable in that case.
- A breakpoint masked by `skip_bp` is not re-checked until the next RUN cycle.

## Timing
- Asynchronous reset (`rst_n`=0) forces, immediately and independent of `clk`:
  - state IDLE, `cycle_count`=0, `halt_cause`=0, `skip_bp`=0, reset counter 0.
  - Resulting outputs: `cpu_en`=0, `cpu_rst_n`=0, `running`=0, `halted`=0.
- Reset asserted mid-RUN gates `cpu_en` off within the same cycle, before the next edge.
- `start` sampled at edge N → state CPURST from N. `cpu_rst_n` stays 0 through edge N+RST_CYCLES. RUN begins at edge N+RST_CYCLES, and `cpu_en` can be 1 from that cycle.
- Halt latency: a stop condition true in cycle C gives `cpu_en`=0 in C and `halted`=1 after edge C.
- Step: `step` at edge N gives STEP during cycle N→N+1 and HALTED again after edge N+1.
- All inputs are synchronous to `clk`. `pc` must be valid and settled before the edge.

## Test plan
- Reset, then `start` with RST_CYCLES=2 and limit 0 → `cpu_rst_n`=0 for 2 cycles, then `cpu_en`=1 every cycle; `cycle_count`=5 after 5 RUN cycles.
- `cycle_limit`=10 → exactly 10 `cpu_en` pulses, then HALTED with `halt_cause`=3 and `cycle_count`=10. `resume` → halts again immediately, 0 extra pulses. `step` → count 11, HALTED.
- `bp_en`=1, `bp_addr`=0x0C, PC advances by 4 per cycle from 0 → halts with `pc`=0x0C, cause 2, count 3. `resume` → 0x0C executes and the core continues to 0x10 and beyond.
- `halt_req` pulsed together with a breakpoint match → cause 1. Three `step` pulses → exactly 3 `cpu_en` cycles, `halted`=1 after each.
- In HALTED, `start`, `resume` and `step` asserted together → CPURST, `cycle_count`=0, `halt_cause`=0.
- `rst_n` dropped mid-RUN between clock edges → `cpu_en`=0 and `cpu_rst_n`=0 immediately; with `CNT_W`=4, limit 0 and a long run, `cycle_count` saturates at 15.
